// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types and sizes for the MIPS register bank write stage
package regbank_pkg;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [AW-1:0] regaddr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;
endpackage

// File: rtl/reg_bank_write_if.sv
// rtl/reg_bank_write_if.sv - write port, clear handshake and register outputs of the bank
interface reg_bank_write_if
    import regbank_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic                             we;
    regaddr_t                         wa;
    logic [WIDTH-1:0]                 wd;
    logic                             clr_req;
    logic                             busy;
    logic                             wr_drop;
    logic [NREGS-1:0][WIDTH-1:0]      q;

    modport master (
        output we, wa, wd, clr_req,
        input  busy, wr_drop, q
    );

    modport slave (
        input  we, wa, wd, clr_req,
        output busy, wr_drop, q
    );
endinterface

// File: rtl/dec5to32.sv
// rtl/dec5to32.sv - 5-to-32 one-hot write address decoder
module dec5to32
    import regbank_pkg::*;
(
    input  regaddr_t    wa,
    output logic [31:0] sel
);
    always_comb begin
        sel = '0;
        for (int i = 0; i < 32; i++) begin
            sel[i] = (wa == regaddr_t'(i));
        end
    end
endmodule

// File: rtl/reg_bank_write.sv
// rtl/reg_bank_write.sv - register storage, single write port and sequenced bank clear
module reg_bank_write #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    reg_bank_write_if.slave  bus
);
    import regbank_pkg::*;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    regaddr_t         cnt;
    logic [31:0]      sel;
    logic             accept;
    logic             in_sweep;
    logic [WIDTH-1:0] regs [1:NREGS-1];

    dec5to32 u_dec (
        .wa  (bus.wa),
        .sel (sel)
    );

    // A pending clear always beats a write presented in the same cycle.
    assign accept   = bus.we && (state == ST_IDLE) && !bus.clr_req;
    assign in_sweep = (state == ST_SWEEP);
    assign bus.busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bus.wr_drop <= 1'b0;
        end else begin
            bus.wr_drop <= bus.we && (bus.wa != '0) && !accept;
            case (state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state <= ST_SWEEP;
                        cnt   <= regaddr_t'(1);
                    end
                end
                ST_SWEEP: begin
                    if (cnt == regaddr_t'(NREGS - 1)) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + regaddr_t'(1);
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Register 0 has no storage; the sweep and the write port never overlap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (in_sweep && (cnt == regaddr_t'(i))) begin
                    regs[i] <= '0;
                end else if (accept && sel[i]) begin
                    regs[i] <= bus.wd;
                end
            end
        end
    end

    always_comb begin
        bus.q    = '0;
        for (int i = 1; i < NREGS; i++) begin
            bus.q[i] = regs[i];
        end
    end
endmodule

// File: tb/tb_reg_bank_write.sv
// tb/tb_reg_bank_write.sv - directed self-checking bench for reg_bank_write
module tb_reg_bank_write;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_q [32];

    reg_bank_write_if #(.WIDTH(32)) bus ();

    reg_bank_write #(.WIDTH(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1;
        bus.wa = a;
        bus.wd = d;
        @(negedge clk);
        bus.we = 1'b0;
        if (a != 5'd0) exp_q[a] = d;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout busy=%b expected=0", name, bus.busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.clr_req = 1'b0;
        for (int i = 0; i < 32; i++) exp_q[i] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.q !== '0) begin failures++; $display("FAIL reset_q q_nonzero expected all 0"); end
        checks++;
        if (bus.busy !== 1'b0 || bus.wr_drop !== 1'b0) begin
            failures++; $display("FAIL reset_flags busy=%b wr_drop=%b expected 0 0", bus.busy, bus.wr_drop);
        end
        reset = 1'b0;
        do_write(5'd3, 32'h0000_0055);
        do_write(5'd9, 32'h9999_0000);
        checks++;
        if (bus.q[9] !== 32'h9999_0000) begin failures++; $display("FAIL pre_reset_write q9=%h expected=99990000", bus.q[9]); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.q[3] !== 32'h0 || bus.q[9] !== 32'h0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL async_reset q3=%h q9=%h busy=%b expected 0 0 0", bus.q[3], bus.q[9], bus.busy);
        end
        exp_q[3] = '0; exp_q[9] = '0;
        @(negedge clk);
        reset = 1'b0;
        do_write(5'd5, 32'hDEAD_BEEF);
        checks++;
        if (bus.q[5] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL write_r5 q5=%h expected=deadbeef", bus.q[5]); end
    endtask

    task automatic test_r0_r31;
        do_write(5'd0, 32'h1234_5678);
        checks++;
        if (bus.q[0] !== 32'h0 || bus.wr_drop !== 1'b0) begin
            failures++; $display("FAIL write_r0 q0=%h wr_drop=%b expected 0 0", bus.q[0], bus.wr_drop);
        end
        do_write(5'd31, 32'hFFFF_FFFF);
        checks++;
        if (bus.q[31] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL write_r31 q31=%h expected=ffffffff", bus.q[31]); end
        for (int i = 0; i < 31; i++) begin
            checks++;
            if (bus.q[i] !== exp_q[i]) begin failures++; $display("FAIL r31_others q%0d=%h expected=%h", i, bus.q[i], exp_q[i]); end
        end
    endtask

    task automatic test_sweep;
        int busy_cycles = 0;
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h1111_1111);
        checks++;
        if (bus.q[17] !== 32'h2222_2221) begin failures++; $display("FAIL fill_r17 q17=%h expected=22222221", bus.q[17]); end
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        if (bus.busy) busy_cycles++;
        checks++;
        if (bus.busy !== 1'b1 || bus.q[1] !== exp_q[1]) begin
            failures++; $display("FAIL sweep_start busy=%b q1=%h expected 1 %h", bus.busy, bus.q[1], exp_q[1]);
        end
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            checks++;
            if (bus.q[k] !== 32'h0) begin failures++; $display("FAIL sweep_clear k=%0d q=%h expected=0", k, bus.q[k]); end
            if (k < 31) begin
                checks++;
                if (bus.q[k+1] !== exp_q[k+1]) begin
                    failures++; $display("FAIL sweep_ahead k=%0d q=%h expected=%h", k + 1, bus.q[k+1], exp_q[k+1]);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL done_busy busy=%b expected=1", bus.busy); end
        @(negedge clk);
        if (bus.busy) busy_cycles++;
        checks++;
        if (busy_cycles != 32 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL busy_len cycles=%0d busy=%b expected 32 0", busy_cycles, bus.busy);
        end
        for (int i = 0; i < 32; i++) exp_q[i] = '0;
        checks++;
        if (bus.q !== '0) begin failures++; $display("FAIL sweep_all_zero q not all zero expected 0"); end
    endtask

    task automatic test_clr_and_write;
        do_write(5'd7, 32'h0000_0001);
        bus.clr_req = 1'b1;
        do_write(5'd7, 32'hA5A5_A5A5);
        exp_q[7] = 32'h0000_0001;
        bus.clr_req = 1'b0;
        checks++;
        if (bus.wr_drop !== 1'b1 || bus.q[7] !== 32'h0000_0001) begin
            failures++; $display("FAIL clr_write_drop wr_drop=%b q7=%h expected 1 00000001", bus.wr_drop, bus.q[7]);
        end
        @(negedge clk);
        checks++;
        if (bus.wr_drop !== 1'b0) begin failures++; $display("FAIL drop_pulse wr_drop=%b expected=0", bus.wr_drop); end
        wait_idle("clr_write");
        exp_q[7] = '0;
        checks++;
        if (bus.q[7] !== 32'h0) begin failures++; $display("FAIL clr_write_q7 q7=%h expected=0", bus.q[7]); end
    endtask

    task automatic test_write_during_sweep;
        do_write(5'd20, 32'h0000_0077);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (2) @(negedge clk);
        do_write(5'd20, 32'hCAFE_F00D);
        exp_q[20] = 32'h0000_0077;
        checks++;
        if (bus.wr_drop !== 1'b1 || bus.q[20] !== 32'h0000_0077) begin
            failures++; $display("FAIL sweep_drop wr_drop=%b q20=%h expected 1 00000077", bus.wr_drop, bus.q[20]);
        end
        do_write(5'd0, 32'h1111_0000);
        checks++;
        if (bus.wr_drop !== 1'b0) begin failures++; $display("FAIL sweep_r0_nodrop wr_drop=%b expected=0", bus.wr_drop); end
        wait_idle("sweep_write");
        checks++;
        if (bus.q[20] !== 32'h0) begin failures++; $display("FAIL sweep_q20 q20=%h expected=0", bus.q[20]); end
        do_write(5'd20, 32'h0BAD_CAFE);
        checks++;
        if (bus.q[20] !== 32'h0BAD_CAFE || bus.wr_drop !== 1'b0) begin
            failures++; $display("FAIL post_sweep_write q20=%h wr_drop=%b expected 0badcafe 0", bus.q[20], bus.wr_drop);
        end
    endtask

    task automatic test_reset_mid_sweep;
        do_write(5'd15, 32'h0000_000F);
        do_write(5'd31, 32'h3131_3131);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.q[10] !== 32'h0 || bus.q[15] !== 32'h0000_000F) begin
            failures++; $display("FAIL mid_sweep q10=%h q15=%h expected 0 0000000f", bus.q[10], bus.q[15]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.q !== '0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_sweep q15=%h q31=%h busy=%b expected 0 0 0", bus.q[15], bus.q[31], bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle busy=%b expected=0", bus.busy); end
        do_write(5'd1, 32'h0000_00A1);
        do_write(5'd2, 32'h0000_00A2);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.q[1] !== 32'h0 || bus.q[2] !== 32'h0000_00A2 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL restart_r1 q1=%h q2=%h busy=%b expected 0 000000a2 1", bus.q[1], bus.q[2], bus.busy);
        end
        wait_idle("restart");
        checks++;
        if (bus.q !== '0) begin failures++; $display("FAIL restart_all_zero q not all zero expected 0"); end
    endtask

    initial begin
        test_reset;
        test_r0_r31;
        test_sweep;
        test_clr_and_write;
        test_write_during_sweep;
        test_reset_mid_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
